// File: rtl/serial_adder_pkg.sv
// Shared types for the nibble-serial adder sequencer.
// State encoding and nibble geometry.
package serial_adder_pkg;

  typedef enum logic {
    IDLE,
    ADD
  } adder_state_t;

  localparam int NIBBLE_BITS = 4;

endpackage

// File: rtl/adder_4bit.sv
// Shared 4-bit ripple adder with carry in/out.
// Purely combinational.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Adds two wide operands one nibble per clock through a single 4-bit adder.
// LS nibble first; carry ripples through carry_reg between cycles.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NUM_NIBBLES = 4,
  localparam int W = NIBBLE_BITS * NUM_NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         overflow
);

  localparam int CW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_NIBBLES - 1);

  adder_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          carry_reg, carry_nxt;
  logic [W-1:0]  op_a, op_a_nxt;
  logic [W-1:0]  op_b, op_b_nxt;
  logic [W-1:0]  accum, accum_nxt;
  logic [W-1:0]  sum_nxt;
  logic          ovf_nxt;
  logic          done_nxt;

  logic [NIBBLE_BITS-1:0] nib_a, nib_b, nib_sum;
  logic                   nib_ovf;

  assign nib_a = op_a[NIBBLE_BITS*cnt +: NIBBLE_BITS];
  assign nib_b = op_b[NIBBLE_BITS*cnt +: NIBBLE_BITS];

  adder_4bit u_adder (
    .a        (nib_a),
    .b        (nib_b),
    .carry_in (carry_reg),
    .sum      (nib_sum),
    .overflow (nib_ovf)
  );

  assign busy = (state == ADD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    carry_nxt = carry_reg;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    accum_nxt = accum;
    sum_nxt   = sum;
    ovf_nxt   = overflow;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          op_a_nxt  = a;
          op_b_nxt  = b;
          carry_nxt = carry_in;
          cnt_nxt   = '0;
          state_nxt = ADD;
        end
      end
      ADD: begin
        accum_nxt[NIBBLE_BITS*cnt +: NIBBLE_BITS] = nib_sum;
        carry_nxt = nib_ovf;
        cnt_nxt   = cnt + CW'(1);
        // Last nibble: publish the fully assembled word.
        if (cnt == LAST) begin
          sum_nxt   = accum_nxt;
          ovf_nxt   = nib_ovf;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_reg <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      accum     <= '0;
      sum       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      carry_reg <= carry_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      accum     <= accum_nxt;
      sum       <= sum_nxt;
      overflow  <= ovf_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl.
// Results are compared in the done cycle.
module tb_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, overflow;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.NUM_NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request and return just after the accepting edge E0.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic cv);
    @(negedge clk);
    start = 1'b1;
    a = va;
    b = vb;
    carry_in = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic cv,
                       input logic [W-1:0] es, input logic eo);
    int n, bc;
    launch(va, vb, cv);
    start = 1'b0;
    wait_done(n, bc);
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " sum"}, 32'(sum), 32'(es));
    check({name, " ovf"}, 32'(overflow), 32'(eo));
    check({name, " lat"}, 32'(n), 32'(N));
    check({name, " busy_cyc"}, 32'(bc), 32'(N));
  endtask

  initial begin
    int n, bc, dones;
    logic [W:0] full;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].exp_sum, vecs[i].exp_ovf);

    // start during busy must be ignored
    launch(16'h1234, 16'h4321, 1'b0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = '0;
    b = '0;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("ign sum", 32'(sum), 32'h5555);
    check("ign dones", 32'(dones), 32'd1);
    check("ign idle", 32'(busy), 32'd0);

    // reset in the second ADD cycle
    launch(16'hFFFF, 16'h0001, 1'b0);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    check("mid_rst sum", 32'(sum), 32'd0);
    check("mid_rst ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

    // start held across the done cycle gives back-to-back ops
    launch(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    a = 16'h0F0F;
    b = 16'h00F1;
    wait_done(n, bc);
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first sum", 32'(sum), 32'h5555);
    @(posedge clk);
    #1;
    check("b2b accept", 32'(busy), 32'd1);
    check("b2b done clr", 32'(done), 32'd0);
    check("b2b hold sum", 32'(sum), 32'h5555);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second sum", 32'(sum), 32'h1000);
    check("b2b second ovf", 32'(overflow), 32'd0);
    check("b2b second lat", 32'(n), 32'(N));

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op($sformatf("rnd%0d", i), ra, rb, rc, full[W-1:0], full[W]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
